mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch unit and the load/store path of exec_unit.
- Arbitrates between the two requesters, registers the winner's address, size and write data, and holds that access until the memory signals done.
- Routes mem_done back to the granted requester only.
- Sits between exec_unit/fetch and the memory controller in cpu.sv.

Parameters:
IF_STARVE_MAX, 4, consecutive LSU grants allowed while a fetch waits before fetch is forced to win (1..15)
ADDR_W, 64, address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ls_address  in  ADDR_W  LSU address
ls_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
ls_read  in  1  LSU read request, level, held until ls_done
ls_write  in  1  LSU write request, level, held until ls_done
ls_writedata  in  64  LSU store data
ls_readdata  out  64  read data to LSU
ls_done  out  1  one-cycle completion pulse to LSU
if_address  in  ADDR_W  fetch address, always octa
if_read  in  1  fetch request, level, held until if_done
if_cancel  in  1  pipeline flush; discard the in-flight fetch result
if_readdata  out  64  read data to fetch
if_done  out  1  one-cycle completion pulse to fetch
m_address  out  ADDR_W  registered downstream address
m_datasize  out  2  registered size
m_read  out  1  downstream read
m_write  out  1  downstream write
m_writedata  out  64  registered store data
m_readdata  in  64  downstream read data
m_done  in  1  downstream completion pulse
busy  out  1  high in any grant state
err_rw  out  1  sticky; set when ls_read and ls_write are sampled high together

Behaviour:
- Reset (async, reset_n low):
  - state = S_IDLE; starvation counter = 0; drop flag = 0; err_rw = 0.
  - All m_* outputs and both done pulses = 0.
  - A downstream access in flight is abandoned; a late m_done is ignored in S_IDLE.
- States: S_IDLE, S_LS, S_IF.
- S_IDLE, arbitration decided combinationally and registered at the clock edge:
  - Neither requester active: stay in S_IDLE.
  - Only one active: grant it.
  - Both active: grant LSU unless the counter is at IF_STARVE_MAX, then grant fetch.
- On a grant:
  - Latch address and size. A fetch grant uses size 3 regardless.
  - Latch write data on an LSU write.
  - Register m_read or m_write.
  - Latency: request seen in IDLE cycle N; m_read/m_write is visible from cycle N+1.
- LSU read and write both high: read wins and err_rw sets.
- m_* outputs stay constant for the whole grant. Requester inputs are not re-sampled during a grant.
- S_LS or S_IF with m_done = 1 in cycle M:
  - Pulse the owning done combinationally in cycle M; *_readdata passes m_readdata through.
  - Drop m_read/m_write at the edge ending cycle M and return to S_IDLE.
  - The mandatory idle cycle M+1 lets the requester deassert. Earliest next grant is visible at M+2.
- Starvation counter (4 bits):
  - Increments on an LSU grant made while if_read is high.
  - Clears on a fetch grant, or in S_IDLE when if_read is low.
  - Saturates at IF_STARVE_MAX.
- Cancel:
  - if_cancel high in any cycle of S_IF, including the m_done cycle, sets the drop flag.
  - With the drop flag set, the m_done completion still returns to S_IDLE but if_done stays 0.
  - The drop flag clears on entering S_IDLE.
  - if_cancel in S_IDLE or S_LS has no effect.
- ls_done and if_done are never high together. Neither pulses outside a grant state.
- busy = (state != S_IDLE).

Decomposition:
- Add to mmix_defs package:
  - arb_state_t enum (S_IDLE, S_LS, S_IF)
  - datasize constants DS_BYTE/DS_WYDE/DS_TETRA/DS_OCTA
- No sub-module needed. The starvation counter stays inline.

Test Plan:
1. Fetch-only: if_read=1, addr 0x100 at cycle 0 -> m_read=1, m_address=0x100, m_datasize=3 at cycle 1; m_done at cycle 4 -> if_done=1 in cycle 4 with if_readdata=m_readdata; busy=0 at cycle 5.
2. Simultaneous, IF_STARVE_MAX=2: both requesters continuously active -> grant order LS, LS, IF, LS, LS, IF. ls_done and if_done never coincide; each new grant starts two cycles after the previous m_done.
3. LSU write: ls_write=1, size 0, data 0x1FF, inputs changed mid-grant -> m_write held with size 0, data 0x1FF unchanged until m_done; ls_done single pulse.
4. Cancel: if_cancel pulsed in the m_done cycle of a fetch -> if_done stays 0; state returns to S_IDLE; a waiting LSU request is granted two cycles after that m_done.
5. Reset mid-access: reset_n low during S_LS -> all outputs 0 asynchronously; after release, a stray m_done produces no done pulse and err_rw=0.
6. Protocol error: ls_read=ls_write=1 in IDLE -> m_read=1, m_write=0, err_rw=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  // Arbiter ownership of the downstream memory port
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LS   = 2'd1,
    S_IF   = 2'd2
  } arb_state_t;

  // Access size encodings shared by LSU, fetch and the memory controller
  localparam logic [1:0] DS_BYTE  = 2'd0;
  localparam logic [1:0] DS_WYDE  = 2'd1;
  localparam logic [1:0] DS_TETRA = 2'd2;
  localparam logic [1:0] DS_OCTA  = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - LSU, fetch and downstream memory signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);

  // LSU side
  logic [ADDR_W-1:0] ls_address;
  logic [1:0]        ls_datasize;
  logic              ls_read;
  logic              ls_write;
  logic [63:0]       ls_writedata;
  logic [63:0]       ls_readdata;
  logic              ls_done;

  // Instruction-fetch side
  logic [ADDR_W-1:0] if_address;
  logic              if_read;
  logic              if_cancel;
  logic [63:0]       if_readdata;
  logic              if_done;

  // Downstream memory controller side
  logic [ADDR_W-1:0] m_address;
  logic [1:0]        m_datasize;
  logic              m_read;
  logic              m_write;
  logic [63:0]       m_writedata;
  logic [63:0]       m_readdata;
  logic              m_done;

  // Status
  logic              busy;
  logic              err_rw;

  // Arbiter view
  modport slave (
    input  ls_address, ls_datasize, ls_read, ls_write, ls_writedata,
    output ls_readdata, ls_done,
    input  if_address, if_read, if_cancel,
    output if_readdata, if_done,
    output m_address, m_datasize, m_read, m_write, m_writedata,
    input  m_readdata, m_done,
    output busy, err_rw
  );

  // Environment view: requesters plus memory controller
  modport master (
    output ls_address, ls_datasize, ls_read, ls_write, ls_writedata,
    input  ls_readdata, ls_done,
    output if_address, if_read, if_cancel,
    input  if_readdata, if_done,
    input  m_address, m_datasize, m_read, m_write, m_writedata,
    output m_readdata, m_done,
    input  busy, err_rw
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between LSU and instruction fetch
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int IF_STARVE_MAX = 4,
  parameter int ADDR_W        = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);

  arb_state_t        state_q;
  logic [3:0]        starve_q;
  logic [3:0]        starve_d;
  logic              drop_q;
  logic              err_q;
  logic [ADDR_W-1:0] m_address_q;
  logic [1:0]        m_datasize_q;
  logic              m_read_q;
  logic              m_write_q;
  logic [63:0]       m_writedata_q;

  logic ls_req;
  logic starved;
  logic grant_if;
  logic grant_ls;
  logic ls_is_write;

  // Idle arbitration: LSU normally wins, fetch wins once it has been passed over too often
  always_comb begin
    ls_req      = bus.ls_read | bus.ls_write;
    starved     = (starve_q == STARVE_MAX);
    grant_if    = bus.if_read & (~ls_req | starved);
    grant_ls    = ls_req & ~grant_if;
    ls_is_write = bus.ls_write & ~bus.ls_read;

    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (grant_if || !bus.if_read) begin
        starve_d = 4'd0;
      end else if (grant_ls && !starved) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Grant FSM with registered downstream request, held constant until m_done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      starve_q      <= 4'd0;
      drop_q        <= 1'b0;
      err_q         <= 1'b0;
      m_address_q   <= '0;
      m_datasize_q  <= 2'd0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_writedata_q <= 64'd0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        S_IDLE: begin
          drop_q <= 1'b0;
          if (grant_if) begin
            state_q      <= S_IF;
            m_address_q  <= bus.if_address;
            m_datasize_q <= DS_OCTA;
            m_read_q     <= 1'b1;
            m_write_q    <= 1'b0;
          end else if (grant_ls) begin
            state_q      <= S_LS;
            m_address_q  <= bus.ls_address;
            m_datasize_q <= bus.ls_datasize;
            m_read_q     <= bus.ls_read;
            m_write_q    <= ls_is_write;
            if (ls_is_write) begin
              m_writedata_q <= bus.ls_writedata;
            end
            if (bus.ls_read && bus.ls_write) begin
              err_q <= 1'b1;
            end
          end
        end
        S_LS: begin
          if (bus.m_done) begin
            state_q   <= S_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
          end
        end
        S_IF: begin
          if (bus.if_cancel) begin
            drop_q <= 1'b1;
          end
          if (bus.m_done) begin
            state_q   <= S_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            drop_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Completion is routed only to the owner; a cancel in the m_done cycle already suppresses if_done
  assign bus.ls_done     = (state_q == S_LS) & bus.m_done;
  assign bus.if_done     = (state_q == S_IF) & bus.m_done & ~drop_q & ~bus.if_cancel;
  assign bus.ls_readdata = bus.m_readdata;
  assign bus.if_readdata = bus.m_readdata;

  assign bus.m_address   = m_address_q;
  assign bus.m_datasize  = m_datasize_q;
  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_writedata = m_writedata_q;

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.err_rw      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit [5:0] if_turn;
  logic [63:0] exp_addr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_port_arbiter #(
    .IF_STARVE_MAX(2),
    .ADDR_W       (64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.ls_address   = '0;
    bus.ls_datasize  = 2'd0;
    bus.ls_read      = 1'b0;
    bus.ls_write     = 1'b0;
    bus.ls_writedata = 64'd0;
    bus.if_address   = '0;
    bus.if_read      = 1'b0;
    bus.if_cancel    = 1'b0;
    bus.m_readdata   = 64'd0;
    bus.m_done       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    smp();
    chk("rst_busy",   64'(bus.busy),      64'd0);
    chk("rst_m_read", 64'(bus.m_read),    64'd0);
    chk("rst_m_wr",   64'(bus.m_write),   64'd0);
    chk("rst_m_addr", bus.m_address,      64'd0);
    chk("rst_err",    64'(bus.err_rw),    64'd0);
    chk("rst_ls_dn",  64'(bus.ls_done),   64'd0);
    chk("rst_if_dn",  64'(bus.if_done),   64'd0);
    cyc();
    reset_n = 1'b1;

    // Fetch-only access
    cyc();
    bus.if_read    = 1'b1;
    bus.if_address = 64'h100;
    smp();
    chk("f_c0_mread", 64'(bus.m_read), 64'd0);
    cyc();
    smp();
    chk("f_c1_mread", 64'(bus.m_read),     64'd1);
    chk("f_c1_addr",  bus.m_address,       64'h100);
    chk("f_c1_size",  64'(bus.m_datasize), 64'(DS_OCTA));
    chk("f_c1_busy",  64'(bus.busy),       64'd1);
    cyc();
    cyc();
    cyc();
    bus.m_done     = 1'b1;
    bus.m_readdata = 64'hDEAD_BEEF_0123_4567;
    smp();
    chk("f_c4_ifdone", 64'(bus.if_done), 64'd1);
    chk("f_c4_rdata",  bus.if_readdata,  64'hDEAD_BEEF_0123_4567);
    chk("f_c4_lsdone", 64'(bus.ls_done), 64'd0);
    cyc();
    bus.m_done  = 1'b0;
    bus.if_read = 1'b0;
    smp();
    chk("f_c5_busy",   64'(bus.busy),    64'd0);
    chk("f_c5_mread",  64'(bus.m_read),  64'd0);
    chk("f_c5_ifdone", 64'(bus.if_done), 64'd0);

    // LSU write with inputs changed mid-grant
    cyc();
    bus.ls_write     = 1'b1;
    bus.ls_datasize  = DS_BYTE;
    bus.ls_address   = 64'h2000;
    bus.ls_writedata = 64'h1FF;
    smp();
    cyc();
    bus.ls_address   = 64'h3000;
    bus.ls_writedata = 64'hABCD;
    bus.ls_datasize  = DS_OCTA;
    smp();
    chk("w_c1_mwrite", 64'(bus.m_write),     64'd1);
    chk("w_c1_mread",  64'(bus.m_read),      64'd0);
    chk("w_c1_size",   64'(bus.m_datasize),  64'd0);
    chk("w_c1_data",   bus.m_writedata,      64'h1FF);
    chk("w_c1_addr",   bus.m_address,        64'h2000);
    cyc();
    smp();
    chk("w_c2_data",   bus.m_writedata,      64'h1FF);
    chk("w_c2_lsdone", 64'(bus.ls_done),     64'd0);
    cyc();
    bus.m_done = 1'b1;
    smp();
    chk("w_c3_lsdone", 64'(bus.ls_done),     64'd1);
    chk("w_c3_ifdone", 64'(bus.if_done),     64'd0);
    chk("w_c3_mwrite", 64'(bus.m_write),     64'd1);
    chk("w_c3_addr",   bus.m_address,        64'h2000);
    cyc();
    bus.m_done   = 1'b0;
    bus.ls_write = 1'b0;
    smp();
    chk("w_c4_lsdone", 64'(bus.ls_done),     64'd0);
    chk("w_c4_mwrite", 64'(bus.m_write),     64'd0);
    chk("w_c4_busy",   64'(bus.busy),        64'd0);
    chk("w_c4_err",    64'(bus.err_rw),      64'd0);

    // Both requesters continuously active: LS, LS, IF repeating
    if_turn = 6'b100100;
    cyc();
    bus.ls_read     = 1'b1;
    bus.ls_address  = 64'h40;
    bus.ls_datasize = DS_TETRA;
    bus.if_read     = 1'b1;
    bus.if_address  = 64'h80;
    smp();
    for (int i = 0; i < 6; i++) begin
      exp_addr = if_turn[i] ? 64'h80 : 64'h40;
      cyc();
      smp();
      chk($sformatf("s%0d_busy", i),  64'(bus.busy),   64'd1);
      chk($sformatf("s%0d_addr", i),  bus.m_address,   exp_addr);
      chk($sformatf("s%0d_mread", i), 64'(bus.m_read), 64'd1);
      cyc();
      bus.m_done = 1'b1;
      smp();
      chk($sformatf("s%0d_lsdone", i),  64'(bus.ls_done), 64'(!if_turn[i]));
      chk($sformatf("s%0d_ifdone", i),  64'(bus.if_done), 64'(if_turn[i]));
      chk($sformatf("s%0d_overlap", i), 64'(bus.ls_done & bus.if_done), 64'd0);
      cyc();
      bus.m_done = 1'b0;
      if (i == 5) begin
        bus.ls_read = 1'b0;
        bus.if_read = 1'b0;
      end
      smp();
      chk($sformatf("s%0d_idle", i), 64'(bus.busy), 64'd0);
    end

    // Fetch cancelled in its m_done cycle while LSU waits
    cyc();
    bus.if_read    = 1'b1;
    bus.if_address = 64'h200;
    smp();
    cyc();
    bus.ls_read     = 1'b1;
    bus.ls_address  = 64'h300;
    bus.ls_datasize = DS_WYDE;
    smp();
    chk("c_c1_addr", bus.m_address, 64'h200);
    cyc();
    bus.m_done     = 1'b1;
    bus.if_cancel  = 1'b1;
    bus.m_readdata = 64'h55;
    smp();
    chk("c_c2_ifdone", 64'(bus.if_done), 64'd0);
    chk("c_c2_lsdone", 64'(bus.ls_done), 64'd0);
    cyc();
    bus.m_done    = 1'b0;
    bus.if_cancel = 1'b0;
    bus.if_read   = 1'b0;
    smp();
    chk("c_c3_busy", 64'(bus.busy), 64'd0);
    cyc();
    smp();
    chk("c_c4_addr",  bus.m_address,       64'h300);
    chk("c_c4_mread", 64'(bus.m_read),     64'd1);
    chk("c_c4_size",  64'(bus.m_datasize), 64'(DS_WYDE));
    cyc();
    bus.m_done     = 1'b1;
    bus.if_cancel  = 1'b1;
    bus.m_readdata = 64'h0123_4567_89AB_CDEF;
    smp();
    chk("c_ls_done",  64'(bus.ls_done), 64'd1);
    chk("c_ls_rdata", bus.ls_readdata,  64'h0123_4567_89AB_CDEF);
    cyc();
    bus.m_done    = 1'b0;
    bus.if_cancel = 1'b0;
    bus.ls_read   = 1'b0;
    smp();
    chk("c_end_busy", 64'(bus.busy), 64'd0);

    // Protocol error: read and write together
    cyc();
    bus.ls_read    = 1'b1;
    bus.ls_write   = 1'b1;
    bus.ls_address = 64'h400;
    smp();
    chk("e_c0_err", 64'(bus.err_rw), 64'd0);
    cyc();
    smp();
    chk("e_c1_mread",  64'(bus.m_read),  64'd1);
    chk("e_c1_mwrite", 64'(bus.m_write), 64'd0);
    chk("e_c1_err",    64'(bus.err_rw),  64'd1);
    cyc();
    bus.m_done = 1'b1;
    smp();
    chk("e_c2_lsdone", 64'(bus.ls_done), 64'd1);
    cyc();
    bus.m_done   = 1'b0;
    bus.ls_read  = 1'b0;
    bus.ls_write = 1'b0;
    smp();
    chk("e_c3_err",  64'(bus.err_rw), 64'd1);
    chk("e_c3_busy", 64'(bus.busy),   64'd0);
    cyc();
    smp();
    chk("e_c4_err", 64'(bus.err_rw), 64'd1);

    // Reset in the middle of an LSU access
    cyc();
    bus.ls_read    = 1'b1;
    bus.ls_address = 64'h500;
    smp();
    cyc();
    smp();
    chk("r_pre_busy", 64'(bus.busy), 64'd1);
    #1;
    reset_n     = 1'b0;
    bus.ls_read = 1'b0;
    #1;
    chk("r_async_busy",  64'(bus.busy),      64'd0);
    chk("r_async_mread", 64'(bus.m_read),    64'd0);
    chk("r_async_addr",  bus.m_address,      64'd0);
    chk("r_async_err",   64'(bus.err_rw),    64'd0);
    chk("r_async_lsdn",  64'(bus.ls_done),   64'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    bus.m_done = 1'b1;
    smp();
    chk("r_stray_lsdone", 64'(bus.ls_done), 64'd0);
    chk("r_stray_ifdone", 64'(bus.if_done), 64'd0);
    chk("r_stray_busy",   64'(bus.busy),    64'd0);
    chk("r_stray_err",    64'(bus.err_rw),  64'd0);
    cyc();
    bus.m_done = 1'b0;
    smp();
    chk("r_after_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
